data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 97 +++++++++
 tb/tb_data_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: internal word RAM with zero-wait stores and
// two-cycle registered loads, rejecting misaligned or out-of-range requests.
module data_mem_ctrl #(
    parameter int mbus  = 32,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    input  logic            MWE,
    input  logic            MRE,
    output logic [mbus-1:0] loadedData,
    output logic            stall,
    output logic            loadValid,
    output logic            addrFault
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [mbus-1:0] ram [DEPTH];
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   word_idx;
    logic            aligned;
    logic            in_range;
    logic            one_op;
    logic            legal;
    logic            ram_we;

    // Every upper address bit must be zero so high addresses never alias
    // onto a valid word.
    always_comb begin
        aligned  = (addressData[1:0] == 2'b00);
        in_range = (addressData[mbus-1:AW+2] == '0);
        one_op   = MWE ^ MRE;
        legal    = aligned && in_range && one_op;
        word_idx = addressData[AW+1:2];
        ram_we   = rst && (state == IDLE) && legal && MWE;
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[word_idx] <= storeData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            loadedData <= '0;
            stall      <= 1'b0;
            loadValid  <= 1'b0;
            addrFault  <= 1'b0;
        end else begin
            loadValid <= 1'b0;
            addrFault <= 1'b0;
            case (state)
                IDLE: begin
                    stall <= 1'b0;
                    if (MWE || MRE) begin
                        if (!legal) begin
                            addrFault <= 1'b1;
                        end else if (MRE) begin
                            idx_q <= word_idx;
                            state <= READ;
                            stall <= 1'b1;
                        end
                    end
                end
                READ: begin
                    loadedData <= ram[idx_q];
                    state      <= DONE;
                    stall      <= 1'b1;
                end
                // Requests presented here are the held load and are ignored.
                DONE: begin
                    loadValid <= 1'b1;
                    stall     <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    stall <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a transaction-level
// model of the load/store/fault rules.
module tb_data_mem_ctrl;

    localparam int MBUS  = 32;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [MBUS-1:0] addressData = '0;
    logic [MBUS-1:0] storeData = '0;
    logic            MWE = 1'b0;
    logic            MRE = 1'b0;
    logic [MBUS-1:0] loadedData;
    logic            stall;
    logic            loadValid;
    logic            addrFault;

    data_mem_ctrl #(.mbus(MBUS), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .addressData(addressData),
        .storeData(storeData),
        .MWE(MWE),
        .MRE(MRE),
        .loadedData(loadedData),
        .stall(stall),
        .loadValid(loadValid),
        .addrFault(addrFault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model: cycles left until the load result is returned, plus a word memory.
    int              busy = 0;
    int              pidx = 0;
    logic [MBUS-1:0] mem [DEPTH];
    bit              known [DEPTH];
    logic [MBUS-1:0] exp_ld = '0;
    bit              exp_ld_known = 1'b1;
    bit              exp_stall = 1'b0;
    bit              exp_lv = 1'b0;
    bit              exp_fault = 1'b0;

    task automatic chk(input string nm, input logic [MBUS-1:0] got, input logic [MBUS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0;
        exp_ld = '0;
        exp_ld_known = 1'b1;
        exp_stall = 1'b0;
        exp_lv = 1'b0;
        exp_fault = 1'b0;
    endtask

    // Applies one clock edge's worth of behaviour using the inputs seen at that edge.
    task automatic model_step();
        bit legal;
        if (!rst) begin
            model_reset();
            return;
        end
        exp_lv = 1'b0;
        exp_fault = 1'b0;
        if (busy == 2) begin
            busy = 1;
            exp_ld_known = known[pidx];
            if (known[pidx]) exp_ld = mem[pidx];
        end else if (busy == 1) begin
            busy = 0;
            exp_lv = 1'b1;
        end else if (MWE || MRE) begin
            legal = (MWE != MRE) && (addressData % 4 == 0) && (addressData < 32'(4 * DEPTH));
            if (!legal) begin
                exp_fault = 1'b1;
            end else if (MWE) begin
                mem[addressData / 4] = storeData;
                known[addressData / 4] = 1'b1;
            end else begin
                pidx = int'(addressData / 4);
                busy = 2;
            end
        end
        exp_stall = (busy > 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit we, input bit re, input logic [MBUS-1:0] a, input logic [MBUS-1:0] d);
        MWE = we;
        MRE = re;
        addressData = a;
        storeData = d;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("loadValid", {31'b0, loadValid}, {31'b0, exp_lv});
            chk("addrFault", {31'b0, addrFault}, {31'b0, exp_fault});
            if (exp_ld_known) chk("loadedData", loadedData, exp_ld);
        end
    end

    initial begin
        logic [MBUS-1:0] a;
        int r;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_loadedData", loadedData, 32'd0);
        chk("reset_loadValid", {31'b0, loadValid}, 32'd0);
        chk("reset_addrFault", {31'b0, addrFault}, 32'd0);
        check_en = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Store 9 to word 3, then load it back on the very next cycle.
        drive(1, 0, 32'h0000_000C, 32'd9);
        cyc();
        chk("st_stall", {31'b0, stall}, 32'd0);
        chk("st_fault", {31'b0, addrFault}, 32'd0);
        chk("model_word3", mem[3], 32'd9);
        drive(0, 1, 32'h0000_000C, 32'd0);
        cyc();
        chk("ld_stall1", {31'b0, stall}, 32'd1);
        cyc();
        chk("ld_stall2", {31'b0, stall}, 32'd1);
        chk("ld_early_valid", {31'b0, loadValid}, 32'd0);
        cyc();
        chk("ld_valid", {31'b0, loadValid}, 32'd1);
        chk("ld_data", loadedData, 32'h0000_0009);
        chk("model_ld_data", exp_ld, 32'h0000_0009);
        chk("ld_stall_drop", {31'b0, stall}, 32'd0);
        drive(0, 0, '0, '0);
        cyc();
        chk("ld_valid_pulse", {31'b0, loadValid}, 32'd0);

        // Misaligned store faults and leaves word 3 untouched.
        drive(1, 0, 32'h0000_000D, 32'h3F);
        cyc();
        chk("misalign_fault", {31'b0, addrFault}, 32'd1);
        drive(0, 0, '0, '0);
        cyc();
        chk("misalign_fault_pulse", {31'b0, addrFault}, 32'd0);
        drive(0, 1, 32'h0000_000C, '0);
        cyc(); cyc(); cyc();
        chk("word3_kept", loadedData, 32'd9);

        // Both enables, then an out-of-range load.
        drive(1, 1, 32'h0000_0010, 32'hAA);
        cyc();
        chk("both_fault", {31'b0, addrFault}, 32'd1);
        chk("both_stall", {31'b0, stall}, 32'd0);
        drive(0, 1, 32'h0000_0100, '0);
        cyc();
        chk("range_fault", {31'b0, addrFault}, 32'd1);
        chk("range_stall", {31'b0, stall}, 32'd0);
        chk("model_word4_unwritten", {31'b0, known[4]}, 32'd0);

        // Store then immediate load of word 2.
        drive(1, 0, 32'h0000_0008, 32'h3F);
        cyc();
        drive(0, 1, 32'h0000_0008, '0);
        cyc(); cyc(); cyc();
        chk("wbr_valid", {31'b0, loadValid}, 32'd1);
        chk("wbr_data", loadedData, 32'h0000_003F);

        // Reset during READ aborts the load.
        drive(0, 1, 32'h0000_0008, '0);
        cyc();
        rst = 1'b0;
        #1;
        model_reset();
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_data", loadedData, 32'd0);
        drive(0, 0, '0, '0);
        cyc(); cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_no_valid", {31'b0, loadValid}, 32'd0);
        end
        drive(1, 0, 32'h0000_0004, 32'h55);
        cyc();
        chk("post_abort_store_stall", {31'b0, stall}, 32'd0);
        drive(0, 1, 32'h0000_0004, '0);
        cyc(); cyc(); cyc();
        chk("post_abort_load", loadedData, 32'h55);
        drive(0, 0, '0, '0);
        cyc();

        // Fill every word so random loads have defined results.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 32'(i * 4), $urandom);
            cyc();
        end

        for (int n = 0; n < 4000; n++) begin
            if (n % 701 == 350) begin
                rst = 1'b0;
                #1;
                model_reset();
                cyc();
                rst = 1'b1;
            end
            if (!(busy > 0 && $urandom_range(1, 0) == 1)) begin
                a = 32'($urandom_range(DEPTH - 1, 0) * 4);
                r = $urandom_range(9, 0);
                case ($urandom_range(7, 0))
                    0: a = a | 32'($urandom_range(3, 1));
                    1: a = a | (32'd1 << $urandom_range(MBUS - 1, 8));
                    default: ;
                endcase
                case (r)
                    0, 1:    drive(0, 0, a, $urandom);
                    2, 3, 4: drive(1, 0, a, $urandom);
                    5, 6, 7: drive(0, 1, a, $urandom);
                    default: drive(1, 1, a, $urandom);
                endcase
            end
            cyc();
        end

        drive(0, 0, '0, '0);
        cyc(); cyc(); cyc();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
